dcache_mem_ctrl: RTL and testbench
==================================

# dcache_mem_ctrl

Memory-side controller sitting directly downstream of the 2-way data cache, between the cache and main memory. It accepts dirty-line evictions into a small write buffer and drains them to memory in the background. It services read-miss fill requests with priority over draining, forwarding data straight from the write buffer when the missed word is still buffered. All memory traffic goes through one req/ack port.

## Interface
- DEPTH, 4, write-buffer entries (power of two, ≥2)
- AW, 32, address width; word-granular, bits [1:0] ignored everywhere
- clk  in  1  all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- wb_valid  in  1  cache pushes an eviction this cycle
- wb_addr  in  AW  eviction word address
- wb_data  in  32  eviction data
- wb_ready  out  1  buffer can accept a push (count < DEPTH)
- fill_req  in  1  read-miss request, level, held with fill_addr stable until fill_valid
- fill_addr  in  AW  missed word address
- fill_valid  out  1  one-cycle pulse, fill_data valid
- fill_data  out  32  returned word
- busy  out  1  state ≠ IDLE or count ≠ 0
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  memory address
- mem_wdata  out  32  write data
- mem_ack  in  1  memory completes the request on the rising edge where ack = 1
- mem_rdata  in  32  read data, valid with mem_ack on reads

## Operation
- Write buffer: circular FIFO, head/tail pointers wrap modulo DEPTH, count 0..DEPTH. Push occurs when wb_valid && wb_ready. A push while full is not accepted; the cache must hold wb_valid. Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, RD, WR, RESP.
- IDLE, fill_req = 1: compare fill_addr[AW-1:2] against all valid entries plus the same-cycle incoming push.
  - Match: capture data from the youngest match (incoming push is youngest) and go to RESP. No memory access.
  - No match: latch the address and go to RD.
- IDLE, fill_req = 0, count > 0: go to WR with the head entry.
- IDLE, otherwise: stay in IDLE.
- RD: mem_req = 1, mem_we = 0, mem_addr = latched address. On mem_ack, capture mem_rdata into fill_data and go to RESP.
- WR: mem_req = 1, mem_we = 1, mem_addr/mem_wdata = head entry. On mem_ack, pop the head and go to IDLE.
- RESP: fill_valid = 1 for exactly one cycle, then IDLE. fill_req is not sampled in RESP.
- No preemption: a fill arriving during WR waits for that write's ack.
- Pushes are accepted in every state, including during RD/WR.
- mem_req/mem_we/mem_addr/mem_wdata are registered and stay stable from assertion until the ack edge. mem_req is 0 in IDLE and RESP.
- Read-after-buffered-write correctness comes from forwarding, so fills may bypass pending writes.

## Timing
- Reset values: fill_valid = 0, fill_data = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, wb_ready = 1, busy = 0. FSM = IDLE, pointers and count = 0.
- Reset mid-operation: the outstanding memory request is abandoned, mem_req drops immediately (asynchronously), and buffered writes are discarded.
- Forwarded fill: accepted at edge N, fill_valid high in cycle N+1.
- Memory fill: accepted at edge N, mem_req high from cycle N+1, ack at edge N+k, fill_valid high in cycle N+k+1. Minimum latency is 2 cycles (k = 1).
- Write drain: IDLE→WR at edge N, mem_req high from N+1. The pop and return to IDLE happen on the ack edge. The next write can start one cycle later (IDLE cycle between writes).
- wb_ready and busy are derived from registered count/state and never combinationally depend on wb_valid.
- A fill_req held across RESP is treated as a new request in the following IDLE cycle. The cache must drop fill_req the cycle after fill_valid.

## Test plan
- Reset while in RD with mem_req = 1 → mem_req = 0 immediately, busy = 0, wb_ready = 1; later fill to 0x100 issues a fresh read.
- Push 0x40/0xAAAA0001, fill_req 0x40 same cycle → fill_valid next cycle with 0xAAAA0001, mem_req never asserted.
- Push 0x80/0x11 then 0x80/0x22, then fill 0x80 → fill_data = 0x22 (youngest wins).
- Push 4 entries while memory acks are withheld → wb_ready = 0 after the 4th, a 5th push is not accepted. Ack one write → wb_ready returns to 1, pointers wrap, and writes drain in push order 1..4.
- Fill 0x200 (not buffered), memory acks after 3 cycles with 0xDEADBEEF → mem_we = 0, mem_addr = 0x200, fill_valid one cycle with 0xDEADBEEF, total latency 4 cycles.
- Fill arrives while a WR is waiting for ack → write completes first, then RD issues. No write is lost and busy stays 1 throughout.

Source files
------------

// File: rtl/dcache_mem_ctrl.sv
// Memory-side controller: buffers dirty evictions, drains them in the background, serves fills with forwarding.
// Latency: forwarded fill 1 cycle after acceptance; memory fill 1 cycle plus ack latency; one write per ack plus an idle cycle.
// Backpressure: wb_ready low while the buffer is full; memory stalls via mem_ack; fill_req is held until fill_valid.
module dcache_mem_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [31:0]   wb_data,
    output logic          wb_ready,
    input  logic          fill_req,
    input  logic [AW-1:0] fill_addr,
    output logic          fill_valid,
    output logic [31:0]   fill_data,
    output logic          busy,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t        state, state_n;
    logic [AW-1:0] buf_addr [DEPTH];
    logic [31:0]   buf_data [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic          push, pop, hit;
    logic [31:0]   hit_data;
    logic          mem_req_n, mem_we_n;
    logic [AW-1:0] mem_addr_n;
    logic [31:0]   mem_wdata_n, fill_data_n;

    assign wb_ready   = (count < (PW+1)'(DEPTH));
    assign busy       = (state != IDLE) || (count != '0);
    assign fill_valid = (state == RESP);
    assign push       = wb_valid && wb_ready;
    assign pop        = (state == WR) && mem_ack;

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail] <= wb_addr;
            buf_data[tail] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fill_data <= '0;
        end else begin
            state     <= state_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            fill_data <= fill_data_n;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        fill_data_n = fill_data;
        hit         = 1'b0;
        hit_data    = '0;

        // Walk oldest to youngest so the last match seen is the youngest; a same-cycle push is younger still.
        for (int i = 0; i < DEPTH; i++) begin
            if (((PW+1)'(i) < count) &&
                (buf_addr[head + PW'(i)][AW-1:2] == fill_addr[AW-1:2])) begin
                hit      = 1'b1;
                hit_data = buf_data[head + PW'(i)];
            end
        end
        if (push && (wb_addr[AW-1:2] == fill_addr[AW-1:2])) begin
            hit      = 1'b1;
            hit_data = wb_data;
        end

        case (state)
            IDLE: begin
                if (fill_req) begin
                    if (hit) begin
                        fill_data_n = hit_data;
                        state_n     = RESP;
                    end else begin
                        mem_req_n  = 1'b1;
                        mem_we_n   = 1'b0;
                        mem_addr_n = fill_addr;
                        state_n    = RD;
                    end
                end else if (count != '0) begin
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = buf_addr[head];
                    mem_wdata_n = buf_data[head];
                    state_n     = WR;
                end
            end
            RD: begin
                if (mem_ack) begin
                    fill_data_n = mem_rdata;
                    mem_req_n   = 1'b0;
                    state_n     = RESP;
                end
            end
            WR: begin
                if (mem_ack) begin
                    mem_req_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Bench for dcache_mem_ctrl: coherent-memory reference model, scoreboard queues and a randomized memory responder.
`timescale 1ns/1ps
module tb_dcache_mem_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk, reset;
    logic        wb_valid, wb_ready, fill_req, fill_valid, busy;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] wb_addr, wb_data, fill_addr, fill_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int          n_chk = 0;
    int          n_pass = 0;
    wr_t         exp_wr[$];
    logic [31:0] exp_fill[$];
    logic [31:0] mem_arr [int unsigned];
    int          mcount = 0;
    int          wr_done = 0;
    int          rd_cnt = 0;
    int          wr_at_rd = 0;
    int          wcnt = 0;
    logic [31:0] last_rd_addr = '0;
    bit          hold_ack = 0;
    logic        prev_req = 0, prev_ack = 0, prev_we = 0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;

    dcache_mem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .fill_req(fill_req), .fill_addr(fill_addr), .fill_valid(fill_valid), .fill_data(fill_data),
        .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Untouched memory words hold a fixed pseudo-random pattern of their address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        int unsigned k = {2'b00, a[31:2]};
        if (mem_arr.exists(k)) return mem_arr[k];
        return (k * 32'h9E3779B9) ^ 32'h5A5A5A5A;
    endfunction

    // A fill must see the most recent pushed value of its word, whether still buffered or already written.
    function automatic logic [31:0] expect_val(input logic [31:0] a);
        logic [31:0] v = mem_val(a);
        foreach (exp_wr[i])
            if (exp_wr[i].addr[31:2] == a[31:2]) v = exp_wr[i].data;
        return v;
    endfunction

    // Memory responder: acks after a random number of cycles unless hold_ack is set.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else begin
                mem_ack = 1'b0;
                if (mem_req && !hold_ack) begin
                    if (wcnt == 0) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_val(mem_addr);
                        wcnt      = $urandom_range(0, 3);
                    end else begin
                        wcnt--;
                    end
                end
            end
        end
    end

    // Monitor: checks outputs against the model and applies what the next edge will commit.
    always @(negedge clk) begin
        if (reset) begin
            exp_wr.delete();
            exp_fill.delete();
            mcount   = 0;
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            bit          room;
            wr_t         w;
            logic [31:0] e;
            room = (mcount < DEPTH);
            if (prev_req && !prev_ack)
                chk(mem_req === 1'b1 && mem_we === prev_we && mem_addr === prev_addr && mem_wdata === prev_wdata,
                    "mem_stable", mem_addr, prev_addr);
            chk(wb_ready === room, "wb_ready", 32'(wb_ready), 32'(room));
            if (fill_valid) begin
                if (exp_fill.size() == 0) begin
                    chk(1'b0, "fill_unexpected", fill_data, '0);
                end else begin
                    e = exp_fill.pop_front();
                    chk(fill_data === e, "fill_data", fill_data, e);
                end
            end
            if (mem_req && mem_ack) begin
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        chk(1'b0, "wr_unexpected", mem_addr, '0);
                    end else begin
                        w = exp_wr.pop_front();
                        chk(mem_addr === w.addr, "wr_addr", mem_addr, w.addr);
                        chk(mem_wdata === w.data, "wr_data", mem_wdata, w.data);
                        mcount--;
                    end
                    mem_arr[{2'b00, mem_addr[31:2]}] = mem_wdata;
                    wr_done++;
                end else begin
                    rd_cnt++;
                    last_rd_addr = mem_addr;
                    wr_at_rd     = wr_done;
                end
            end
            if (wb_valid && room) begin
                w.addr = wb_addr;
                w.data = wb_data;
                exp_wr.push_back(w);
                mcount++;
            end
            prev_req   = mem_req;
            prev_ack   = mem_ack;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] a, input bit wp, input logic [31:0] pa,
                           input logic [31:0] pd, input bit bchk, output int lat);
        fill_req  = 1'b1;
        fill_addr = a;
        if (wp) begin
            wb_valid = 1'b1;
            wb_addr  = pa;
            wb_data  = pd;
        end
        @(negedge clk); #1;
        exp_fill.push_back(expect_val(a));
        @(posedge clk); #1;
        wb_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bchk) chk(busy === 1'b1, "busy_held", 32'(busy), 32'd1);
        end while (!fill_valid && lat < 100);
        chk(fill_valid === 1'b1, "fill_seen", 32'(lat), 32'd100);
        @(posedge clk); #1;
        fill_req = 1'b0;
        @(negedge clk);
        chk(fill_valid === 1'b0, "fill_pulse", 32'(fill_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || exp_wr.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(n < 200, "idle_reached", 32'(n), 32'd200);
        @(posedge clk); #1;
    endtask

    initial begin
        int          n, lat, rd0, wr0;
        logic [31:0] a, pa;
        reset     = 1'b1;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        fill_req  = 1'b0;
        fill_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk(fill_valid === 1'b0, "rst_fill_valid", 32'(fill_valid), 32'd0);
        chk(fill_data === 32'd0, "rst_fill_data", fill_data, 32'd0);
        chk(mem_req === 1'b0, "rst_mem_req", 32'(mem_req), 32'd0);
        chk(mem_we === 1'b0, "rst_mem_we", 32'(mem_we), 32'd0);
        chk(mem_addr === 32'd0, "rst_mem_addr", mem_addr, 32'd0);
        chk(mem_wdata === 32'd0, "rst_mem_wdata", mem_wdata, 32'd0);
        chk(wb_ready === 1'b1, "rst_wb_ready", 32'(wb_ready), 32'd1);
        chk(busy === 1'b0, "rst_busy", 32'(busy), 32'd0);
        step();

        // Reset while a read is outstanding, with a buffered write pending
        hold_ack  = 1'b1;
        fill_req  = 1'b1;
        fill_addr = 32'h100;
        wb_valid  = 1'b1;
        wb_addr   = 32'h600;
        wb_data   = 32'h0000_6666;
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        chk(mem_req === 1'b1 && mem_we === 1'b0, "rd_issued", {mem_req, mem_we}, 32'd2);
        chk(mem_addr === 32'h100, "rd_addr", mem_addr, 32'h100);
        #2 reset = 1'b1;
        #1;
        chk(mem_req === 1'b0, "async_req_drop", 32'(mem_req), 32'd0);
        chk(busy === 1'b0, "reset_busy", 32'(busy), 32'd0);
        chk(wb_ready === 1'b1, "reset_wb_ready", 32'(wb_ready), 32'd1);
        fill_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        hold_ack = 1'b0;
        step();
        rd0 = rd_cnt;
        do_fill(32'h100, 1'b0, '0, '0, 1'b0, lat);
        chk(rd_cnt == rd0 + 1, "fresh_read", 32'(rd_cnt - rd0), 32'd1);
        chk(last_rd_addr === 32'h100, "fresh_read_addr", last_rd_addr, 32'h100);
        wait_idle();
        chk(!mem_arr.exists(32'h600 >> 2), "reset_discard", 32'(mem_arr.exists(32'h600 >> 2)), 32'd0);

        // Forward from a same-cycle push
        rd0 = rd_cnt;
        do_fill(32'h40, 1'b1, 32'h40, 32'hAAAA_0001, 1'b0, lat);
        chk(lat == 1, "fwd_latency", 32'(lat), 32'd1);
        chk(rd_cnt == rd0, "fwd_no_read", 32'(rd_cnt - rd0), 32'd0);
        wait_idle();

        // Youngest buffered match wins; fill waits for the write in flight
        hold_ack = 1'b1;
        rd0 = rd_cnt;
        push(32'h300, 32'h33);
        push(32'h80, 32'h11);
        push(32'h80, 32'h22);
        fork
            do_fill(32'h80, 1'b0, '0, '0, 1'b1, lat);
            begin
                repeat (3) @(posedge clk);
                #1 hold_ack = 1'b0;
            end
        join
        chk(fill_data === 32'h22, "youngest", fill_data, 32'h22);
        chk(rd_cnt == rd0, "youngest_no_read", 32'(rd_cnt - rd0), 32'd0);
        wait_idle();

        // Unbuffered fill arriving during a write: write completes, then the read
        hold_ack = 1'b1;
        rd0 = rd_cnt;
        wr0 = wr_done;
        push(32'h340, 32'h44);
        push(32'h344, 32'h55);
        fork
            do_fill(32'h500, 1'b0, '0, '0, 1'b1, lat);
            begin
                repeat (3) @(posedge clk);
                #1 hold_ack = 1'b0;
            end
        join
        chk(rd_cnt == rd0 + 1, "wr_then_rd", 32'(rd_cnt - rd0), 32'd1);
        chk(wr_at_rd == wr0 + 1, "wr_before_rd", 32'(wr_at_rd - wr0), 32'd1);
        chk(last_rd_addr === 32'h500, "wr_then_rd_addr", last_rd_addr, 32'h500);
        wait_idle();

        // Fill the buffer while memory stalls; a fifth push is refused
        hold_ack = 1'b1;
        wr0 = wr_done;
        for (int i = 1; i <= 4; i++) push(32'h700 + 32'(i) * 4, 32'hC0DE_0000 + 32'(i));
        @(negedge clk);
        chk(wb_ready === 1'b0, "full_ready", 32'(wb_ready), 32'd0);
        @(posedge clk); #1;
        push(32'h7F0, 32'hBAD0_0005);
        @(negedge clk);
        chk(wb_ready === 1'b0, "still_full", 32'(wb_ready), 32'd0);
        @(posedge clk); #1;
        hold_ack = 1'b0;
        n = 0;
        while (wr_done == wr0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(wr_done == wr0 + 1, "first_drain", 32'(wr_done - wr0), 32'd1);
        @(negedge clk);
        chk(wb_ready === 1'b1, "ready_after_pop", 32'(wb_ready), 32'd1);
        @(posedge clk); #1;
        wait_idle();
        chk(wr_done == wr0 + 4, "drain_all", 32'(wr_done - wr0), 32'd4);
        chk(!mem_arr.exists(32'h7F0 >> 2), "fifth_refused", 32'(mem_arr.exists(32'h7F0 >> 2)), 32'd0);

        // Memory fill with a 3-cycle ack: 4-cycle total latency
        mem_arr[32'h200 >> 2] = 32'hDEAD_BEEF;
        wcnt = 2;
        rd0 = rd_cnt;
        do_fill(32'h200, 1'b0, '0, '0, 1'b0, lat);
        chk(lat == 4, "mem_latency", 32'(lat), 32'd4);
        chk(rd_cnt == rd0 + 1, "mem_read_once", 32'(rd_cnt - rd0), 32'd1);
        chk(last_rd_addr === 32'h200, "mem_read_addr", last_rd_addr, 32'h200);
        wait_idle();

        // Randomized traffic over a small address set
        for (int it = 0; it < 300; it++) begin
            int r = $urandom_range(0, 9);
            a  = 32'h1000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            pa = 32'h1000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            if (r < 5)      push(a, $urandom);
            else if (r < 7) do_fill(a, 1'($urandom_range(0, 1)), pa, $urandom, 1'b0, lat);
            else            step();
        end
        wait_idle();
        chk(exp_fill.size() == 0, "fill_queue_empty", 32'(exp_fill.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
